// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
//
// Instruction-fetch controller. Owns the program counter, drives the
// combinational-read instruction memory address, and queues fetched words in
// a small in-order buffer that decode drains with a valid/ready handshake.
// Handles redirects from EX, halt requests and out-of-range / misaligned
// fetch faults.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   MEM_BYTES  instruction memory size in bytes (legal fetch 0..MEM_BYTES-4)
//   DEPTH      buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_addr          byte address to instruction memory (== pc_q)
//   imem_instr         instruction word for imem_addr (combinational)
//   if_valid/if_ready  head handshake toward decode
//   if_instr/if_pc     head instruction word and its address
//   redirect_valid/pc  one-cycle branch/jump redirect
//   halt_req           stop fetching once the buffer drains
//   halted             sequencer idle in HALT
//   fetch_fault        sticky out-of-range / misaligned PC fault
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   perf_fetched       saturating count of pushes
//   perf_stall         saturating count of RUN cycles with a legal PC but
//                      no push and no redirect
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 16384,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned   PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW     = $clog2(DEPTH + 1);
    localparam logic [31:0]   PC_MAX = 32'(MEM_BYTES - 4);
    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] ONE    = CW'(1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t        state_q;
    logic [31:0]   pc_q;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   last_pc_q;
    logic [31:0]   last_instr_q;

    logic pc_ok;
    logic redir_ok;
    logic pop;
    logic push;
    logic empty;

    assign empty    = (count_q == '0);
    assign pc_ok    = (pc_q[1:0] == 2'b00) && (pc_q <= PC_MAX);
    assign redir_ok = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= PC_MAX);

    // Head is masked during a redirect so a flushed word can never be taken.
    assign if_valid = !empty && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign push     = (state_q == S_RUN) && !redirect_valid && pc_ok &&
                      ((count_q != FULL) || pop);

    assign imem_addr = pc_q;

    // When empty, present the last head seen (zero after reset).
    assign if_pc    = empty ? last_pc_q    : fifo_pc[rd_q];
    assign if_instr = empty ? last_instr_q : fifo_instr[rd_q];

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_q]    <= pc_q;
            fifo_instr[wr_q] <= imem_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            state_q      <= S_RUN;
            halted       <= 1'b0;
            fetch_fault  <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            count_q      <= '0;
            last_pc_q    <= '0;
            last_instr_q <= '0;
        end else begin
            if (!empty) begin
                last_pc_q    <= fifo_pc[rd_q];
                last_instr_q <= fifo_instr[rd_q];
            end

            if (redirect_valid) begin
                pc_q    <= redirect_pc;
                rd_q    <= '0;
                wr_q    <= '0;
                count_q <= '0;
                if (redir_ok) begin
                    fetch_fault <= 1'b0;
                    state_q     <= halt_req ? S_DRAIN : S_RUN;
                    halted      <= 1'b0;
                end else begin
                    fetch_fault <= 1'b1;
                    state_q     <= S_HALT;
                    halted      <= 1'b1;
                end
            end else begin
                if (push) begin
                    wr_q <= wr_q + PW'(1);
                    pc_q <= pc_q + 32'd4;
                end
                if (pop) begin
                    rd_q <= rd_q + PW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + ONE;
                end else if (pop && !push) begin
                    count_q <= count_q - ONE;
                end

                case (state_q)
                    S_RUN: begin
                        if (!pc_ok) begin
                            fetch_fault <= 1'b1;
                            state_q     <= S_DRAIN;
                        end else if (halt_req) begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (empty || (count_q == ONE && pop)) begin
                            state_q <= S_HALT;
                            halted  <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall;
    assign stall = (state_q == S_RUN) && pc_ok && !push && !redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the pipelined processor. It owns the program counter and drives the address of the byte-addressed, big-endian, combinational-read instruction memory. Fetched words go into a small in-order buffer that the decode stage drains with a valid/ready handshake. It also handles branch/jump redirects, halt requests and out-of-range or misaligned fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
MEM_BYTES, 16384, instruction memory size in bytes; the legal fetch range is 0..MEM_BYTES-4.
DEPTH, 2, buffer entries; power of two, >=2.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
imem_addr  out  32  byte address to instruction memory PC input; always equals pc_q
imem_instr  in  32  instruction word returned combinationally for imem_addr
if_valid  out  1  buffer head valid toward decode
if_ready  in  1  decode accepts head
if_instr  out  32  head instruction word
if_pc  out  32  head instruction address
redirect_valid  in  1  one-cycle branch/jump redirect from EX
redirect_pc  in  32  redirect target (byte address)
halt_req  in  1  stop fetching after buffer drains
halted  out  1  sequencer in HALT
fetch_fault  out  1  sticky fault: out-of-range or misaligned PC

Behaviour:
- Reset (async assert, sync release): pc_q=RESET_PC, buffer empty, state RUN, halted=0, fetch_fault=0, if_valid=0, if_instr=0, if_pc=0.
- States:
  - RUN: fetching.
  - DRAIN: no fetch; buffer empties.
  - HALT: idle.
- pop = if_valid & if_ready.
- push = (state==RUN) & !redirect_valid & pc_ok & (count<DEPTH | pop). Pushes {pc_q, imem_instr}, then pc_q += 4 with 32-bit wrap.
- Push and pop in the same cycle keep count unchanged.
- Throughput is one instruction per cycle.
- Latency: a word addressed in cycle N appears at the head from N+1 at the earliest.
- pc_ok = (pc_q[1:0]==0) & (pc_q <= MEM_BYTES-4).
- if_valid = (count!=0) & !redirect_valid. The head is masked in the redirect cycle, so a flushed instruction can never be accepted.
- if_instr and if_pc hold the head while count!=0, including under backpressure. When empty they hold their last value.
- Redirect (highest priority, any state):
  - Buffer flushed, pc_q <= redirect_pc.
  - If redirect_pc is aligned and in range: fetch_fault<=0; next state is DRAIN if halt_req, else RUN.
  - If not: fetch_fault<=1, next state HALT.
- RUN with !pc_ok and no redirect: no push, fetch_fault<=1, go to DRAIN. Already-buffered words are still delivered.
- RUN with halt_req: go to DRAIN. The fetch in that cycle still occurs.
- DRAIN -> HALT when count==0, or count==1 with pop.
- HALT: halted=1, imem_addr frozen, exits only via redirect or reset.
- halt_req is ignored in DRAIN and HALT.
- Reset mid-stream discards the buffer immediately. No partial state survives.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs perf_fetched[31:0] (increments on push) and perf_stall[31:0] (increments when state==RUN, pc_ok, no push, no redirect).
  - Both are cleared on reset and saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent. Core behaviour is identical.

Test Plan:
1. Reset release, memory words 0x49400000 @0, 0x49410004 @4, 0x49420008 @8, if_ready=1 -> one cycle after the first edge, if_valid=1 with if_pc 0,4,8 on consecutive cycles carrying those words.
2. if_ready=0 for 5 cycles from start -> count saturates at 2, imem_addr holds 0x8, if_instr stays 0x49400000. Release -> 0,4,8 delivered in order, no loss or duplicate.
3. While streaming, redirect_valid=1, redirect_pc=0x9C (word 0x26530000) with if_ready=1 -> if_valid=0 in the redirect cycle. The next accepted item is if_pc=0x9C, if_instr=0x26530000. No pre-redirect PC appears afterwards.
4. halt_req pulse with 2 entries buffered -> exactly 3 further items delivered (2 buffered plus the halt-cycle fetch), then halted=1 and imem_addr frozen. Redirect to 0x28 -> halted=0, fetch resumes at 0x28.
5. Redirect to 0x3FFC -> 0x3FFC delivered, then fetch_fault=1 and halted=1. Redirect to 0x2 -> fetch_fault=1, HALT next cycle, if_valid stays 0. Redirect to 0x0 clears fetch_fault.
6. rst_n asserted asynchronously mid-cycle with 2 entries buffered -> if_valid=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
